// File: rtl/aes_seq_pkg.sv
// Shared types for the iterative AES-128 sequencer:
// command opcodes, FSM states and aes64 operation selects.
package aes_seq_pkg;

   localparam int NROUNDS = 10;

   typedef enum logic [1:0] {
      OP_KEY = 2'b00,
      OP_ENC = 2'b01,
      OP_DEC = 2'b10,
      OP_RSV = 2'b11
   } cmd_op_t;

   typedef enum logic [3:0] {
      IDLE,
      KS1,
      KS2L,
      KS2H,
      ENC_L,
      ENC_H,
      DEC_L,
      DEC_H,
      IMX_L,
      IMX_H,
      RSP
   } state_t;

   typedef enum logic [2:0] {
      A64_KS1,
      A64_KS2,
      A64_IM,
      A64_ES,
      A64_ESM,
      A64_DS,
      A64_DSM
   } a64_op_t;

endpackage

// File: rtl/aes128_seq_rk_store.sv
// Round-key store: 11 x 128-bit entries, one write port,
// one combinational read port (out-of-range read returns 0).
module aes_rk_store
   import aes_seq_pkg::*;
(
   input  logic         clk,
   input  logic         we,
   input  logic [3:0]   widx,
   input  logic [127:0] wdata,
   input  logic [3:0]   ridx,
   output logic [127:0] rdata
);

   logic [127:0] rk_q [NROUNDS+1];

   // contents need no reset; key_valid qualifies them
   always_ff @(posedge clk) begin
      if (we && widx <= 4'(NROUNDS)) rk_q[widx] <= wdata;
   end

   assign rdata = (ridx <= 4'(NROUNDS)) ? rk_q[ridx] : '0;

endmodule

// File: rtl/aes64.sv
// 64-bit AES step unit (RV64 scalar-crypto style): es/esm/ds/dsm, ks1/ks2, im.
// Ports: valid, op, rs1, rs2, enc_rcon in; rd out (zero when !valid).
module aes64
   import aes_seq_pkg::*;
#(
   parameter bit DECRYPT_EN = 1'b1
) (
   input  logic        valid,
   input  a64_op_t     op,
   input  logic [63:0] rs1,
   input  logic [63:0] rs2,
   input  logic [3:0]  enc_rcon,
   output logic [63:0] rd
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // x^254 is the field inverse (and maps 0 to 0)
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] y;
      logic [7:0] r;
      y = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         y = gf_mul(y, y);
         r = gf_mul(r, y);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
               ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] b;
      b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]}
        ^ {y[1:0], y[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [31:0] mix(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a3, a2, a1, a0} = w;
      return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a3, a2, a1, a0} = w;
      return {gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [127:0] st;
   logic [63:0]  sr_f, sr_i, sb_f, sb_i;
   logic [31:0]  ks_r, ks_s, ks_w;
   logic [63:0]  res;

   always_comb begin
      // rs1 holds columns 0-1; swapping rs1/rs2 yields columns 2-3
      st   = {rs2, rs1};
      sr_f = '0;
      sr_i = '0;
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_f[8*(r+4*c) +: 8] = st[8*(r+4*((c+r)%4)) +: 8];
            sr_i[8*(r+4*c) +: 8] = st[8*(r+4*((c-r+4)%4)) +: 8];
         end
      end
      sb_f = '0;
      sb_i = '0;
      for (int i = 0; i < 8; i++) begin
         sb_f[8*i +: 8] = sbox(sr_f[8*i +: 8]);
         sb_i[8*i +: 8] = inv_sbox(sr_i[8*i +: 8]);
      end
      // round 10 of the schedule skips RotWord
      ks_r = (enc_rcon == 4'hA) ? rs1[63:32]
                                : {rs1[39:32], rs1[63:40]};
      for (int i = 0; i < 4; i++)
         ks_s[8*i +: 8] = sbox(ks_r[8*i +: 8]);
      ks_w = ks_s ^ {24'h0, rcon(enc_rcon)};
      res = '0;
      unique case (op)
         A64_KS1: res = {ks_w, ks_w};
         A64_KS2: res = {rs1[63:32] ^ rs2[31:0] ^ rs2[63:32],
                         rs1[63:32] ^ rs2[31:0]};
         A64_ES:  res = sb_f;
         A64_ESM: res = {mix(sb_f[63:32]), mix(sb_f[31:0])};
         A64_DS:  if (DECRYPT_EN) res = sb_i;
         A64_DSM: if (DECRYPT_EN)
            res = {inv_mix(sb_i[63:32]), inv_mix(sb_i[31:0])};
         A64_IM:  if (DECRYPT_EN)
            res = {inv_mix(rs1[63:32]), inv_mix(rs1[31:0])};
         default: res = '0;
      endcase
      rd = valid ? res : '0;
   end

endmodule

// File: rtl/aes128_seq.sv
// Iterative AES-128 key expansion / encrypt / decrypt over one aes64 unit.
// Ports: g_clk, g_reset; cmd_* request, rsp_* response, key_valid, busy.
module aes128_seq
   import aes_seq_pkg::*;
#(
   parameter bit DECRYPT_EN = 1'b1
) (
   input  logic         g_clk,
   input  logic         g_reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [127:0] cmd_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [127:0] rsp_data,
   output logic         rsp_err,
   output logic         key_valid,
   output logic         busy
);

   state_t       state_q, state_d;
   cmd_op_t      op;
   logic         cmd_bad;
   logic [3:0]   rnd_q;
   logic [63:0]  s_lo_q, s_hi_q, t_q;
   logic         kv_q, err_q, dat_q;

   logic         a64_valid;
   a64_op_t      a64_op;
   logic [63:0]  a64_rs1, a64_rs2, a64_rd, kx, a64_x;

   logic         rk_we;
   logic [3:0]   rk_widx, rk_ridx;
   logic [127:0] rk_wdata, rk_rd;

   assign op      = cmd_op_t'(cmd_op);
   assign cmd_bad = (op == OP_RSV)
                  | ((op != OP_KEY) & ~kv_q)
                  | ((op == OP_DEC) & ~DECRYPT_EN);
   assign a64_x   = a64_rd ^ kx;

   aes64 #(.DECRYPT_EN(DECRYPT_EN)) u_aes64 (
      .valid    (a64_valid),
      .op       (a64_op),
      .rs1      (a64_rs1),
      .rs2      (a64_rs2),
      .enc_rcon (rnd_q),
      .rd       (a64_rd)
   );

   aes_rk_store u_rk (
      .clk   (g_clk),
      .we    (rk_we),
      .widx  (rk_widx),
      .wdata (rk_wdata),
      .ridx  (rk_ridx),
      .rdata (rk_rd)
   );

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (cmd_valid) begin
            if (cmd_bad)           state_d = RSP;
            else if (op == OP_KEY) state_d = KS1;
            else if (op == OP_ENC) state_d = ENC_L;
            else                   state_d = DEC_L;
         end
         KS1:   state_d = KS2L;
         KS2L:  state_d = KS2H;
         KS2H:  state_d = (rnd_q == 4'd9) ? RSP : KS1;
         ENC_L: state_d = ENC_H;
         ENC_H: state_d = (rnd_q == 4'(NROUNDS)) ? RSP : ENC_L;
         DEC_L: state_d = DEC_H;
         DEC_H: state_d = (rnd_q == 4'd0) ? RSP : IMX_L;
         IMX_L: state_d = IMX_H;
         IMX_H: state_d = DEC_L;
         RSP:   if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      a64_valid = 1'b1;
      a64_op    = A64_KS2;
      a64_rs1   = '0;
      a64_rs2   = '0;
      kx        = '0;
      rk_we     = 1'b0;
      rk_widx   = rnd_q + 4'd1;
      rk_wdata  = {a64_rd, s_lo_q};
      rk_ridx   = rnd_q;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            a64_valid = 1'b0;
            rk_ridx   = (op == OP_DEC) ? 4'(NROUNDS) : 4'd0;
            if (cmd_valid && op == OP_KEY) begin
               rk_we    = 1'b1;
               rk_widx  = 4'd0;
               rk_wdata = cmd_data;
            end
         end
         KS1: begin
            a64_op  = A64_KS1;
            a64_rs1 = rk_rd[127:64];
         end
         KS2L: begin
            a64_rs1 = t_q;
            a64_rs2 = rk_rd[63:0];
         end
         KS2H: begin
            a64_rs1 = s_lo_q;
            a64_rs2 = rk_rd[127:64];
            rk_we   = 1'b1;
         end
         ENC_L, ENC_H: begin
            a64_op = (rnd_q == 4'(NROUNDS)) ? A64_ES : A64_ESM;
            if (state_q == ENC_L) begin
               a64_rs1 = s_lo_q;
               a64_rs2 = s_hi_q;
               kx      = rk_rd[63:0];
            end else begin
               a64_rs1 = s_hi_q;
               a64_rs2 = s_lo_q;
               kx      = rk_rd[127:64];
            end
         end
         DEC_L, DEC_H: begin
            a64_op = (rnd_q == 4'd0) ? A64_DS : A64_DSM;
            if (state_q == DEC_L) begin
               a64_rs1 = s_lo_q;
               a64_rs2 = s_hi_q;
               if (rnd_q == 4'd0) kx = rk_rd[63:0];
            end else begin
               a64_rs1 = s_hi_q;
               a64_rs2 = s_lo_q;
               if (rnd_q == 4'd0) kx = rk_rd[127:64];
            end
         end
         // equivalent inverse cipher: add InvMix of the round key
         IMX_L: begin
            a64_op  = A64_IM;
            a64_rs1 = rk_rd[63:0];
         end
         IMX_H: begin
            a64_op  = A64_IM;
            a64_rs1 = rk_rd[127:64];
         end
         RSP: begin
            rsp_valid = 1'b1;
            a64_valid = 1'b0;
         end
         default: a64_valid = 1'b0;
      endcase
   end

   assign rsp_err   = rsp_valid & err_q;
   assign rsp_data  = (rsp_valid & dat_q) ? {s_hi_q, s_lo_q} : '0;
   assign key_valid = kv_q;

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         rnd_q  <= '0;
         s_lo_q <= '0;
         s_hi_q <= '0;
         t_q    <= '0;
         kv_q   <= 1'b0;
         err_q  <= 1'b0;
         dat_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (cmd_valid) begin
               err_q <= cmd_bad;
               dat_q <= ~cmd_bad & (op != OP_KEY);
               if (!cmd_bad) begin
                  if (op == OP_KEY) begin
                     rnd_q <= 4'd0;
                     kv_q  <= 1'b0;
                  end else begin
                     rnd_q <= (op == OP_ENC) ? 4'd1 : 4'd9;
                     {s_hi_q, s_lo_q} <= cmd_data ^ rk_rd;
                  end
               end
            end
            KS1:  t_q    <= a64_rd;
            KS2L: s_lo_q <= a64_rd;
            KS2H: begin
               if (rnd_q == 4'd9) kv_q <= 1'b1;
               else               rnd_q <= rnd_q + 4'd1;
            end
            ENC_L, DEC_L: t_q <= a64_x;
            ENC_H: begin
               s_hi_q <= a64_x;
               s_lo_q <= t_q;
               if (rnd_q != 4'(NROUNDS)) rnd_q <= rnd_q + 4'd1;
            end
            DEC_H: begin
               s_hi_q <= a64_x;
               s_lo_q <= t_q;
            end
            IMX_L: s_lo_q <= s_lo_q ^ a64_rd;
            IMX_H: begin
               s_hi_q <= s_hi_q ^ a64_rd;
               rnd_q  <= rnd_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_seq.sv
// Bench for aes128_seq: FIPS-197 vectors, error paths, stalls, reset.
// Two instances: index 0 with decrypt, index 1 without.
module tb_aes128_seq;

   localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] P1 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   localparam logic [127:0] KB = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] PB = 128'h340737e0a29831318d305a88a8f64332;
   localparam logic [127:0] CB = 128'h320b6a19978511dcfb09dc021d842539;

   typedef struct {
      logic [1:0]   op;
      logic [127:0] data;
      logic [127:0] exp;
      logic         err;
      int           lat;
      logic         kv;
   } vec_t;

   logic         g_clk = 1'b0;
   logic         g_reset;
   logic         cmd_valid [2];
   logic         cmd_ready [2];
   logic [1:0]   cmd_op    [2];
   logic [127:0] cmd_data  [2];
   logic         rsp_valid [2];
   logic         rsp_ready [2];
   logic [127:0] rsp_data  [2];
   logic         rsp_err   [2];
   logic         key_valid [2];
   logic         busy      [2];

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t sb_q[$];
   vec_t tbl[12];

   always #5 g_clk = ~g_clk;

   aes128_seq #(.DECRYPT_EN(1'b1)) dut0 (
      .g_clk(g_clk), .g_reset(g_reset),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
      .key_valid(key_valid[0]), .busy(busy[0])
   );

   aes128_seq #(.DECRYPT_EN(1'b0)) dut1 (
      .g_clk(g_clk), .g_reset(g_reset),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
      .key_valid(key_valid[1]), .busy(busy[1])
   );

   function automatic vec_t mk(logic [1:0] op, logic [127:0] d,
                               logic [127:0] e, logic er,
                               int lat, logic kv);
      vec_t v;
      v.op = op; v.data = d; v.exp = e;
      v.err = er; v.lat = lat; v.kv = kv;
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input int d);
      check("rst cmd_ready", 128'(cmd_ready[d]), 128'd1);
      check("rst rsp_valid", 128'(rsp_valid[d]), 128'd0);
      check("rst rsp_data",  rsp_data[d],        128'd0);
      check("rst rsp_err",   128'(rsp_err[d]),   128'd0);
      check("rst key_valid", 128'(key_valid[d]), 128'd0);
      check("rst busy",      128'(busy[d]),      128'd0);
   endtask

   // poke: keep offering a key load while the DUT is busy
   task automatic run_cmd(input int d, input vec_t v,
                          input int hold, input bit poke);
      int   n;
      int   leak;
      vec_t e;
      n = 0;
      leak = 0;
      @(negedge g_clk);
      while (!cmd_ready[d] && n < 100) begin
         @(negedge g_clk);
         n++;
      end
      check("cmd_ready idle", 128'(cmd_ready[d]), 128'd1);
      cmd_valid[d] = 1'b1;
      cmd_op[d]    = v.op;
      cmd_data[d]  = v.data;
      @(posedge g_clk);
      sb_q.push_back(v);
      @(negedge g_clk);
      if (poke) begin
         cmd_op[d]   = 2'b00;
         cmd_data[d] = {$urandom, $urandom, $urandom, $urandom};
      end else begin
         cmd_valid[d] = 1'b0;
      end
      n = 0;
      while (!rsp_valid[d] && n < 200) begin
         if (cmd_ready[d]) leak++;
         @(negedge g_clk);
         n++;
      end
      cmd_valid[d] = 1'b0;
      check("busy cycles", 128'(n), 128'(v.lat));
      if (poke) check("cmd_ready busy", 128'(leak), 128'd0);
      for (int h = 0; h < hold; h++) begin
         check("stall data", rsp_data[d], sb_q[0].exp);
         check("stall cmd_ready", 128'(cmd_ready[d]), 128'd0);
         @(negedge g_clk);
      end
      e = sb_q.pop_front();
      check("rsp_data", rsp_data[d], e.exp);
      check("rsp_err", 128'(rsp_err[d]), 128'(e.err));
      rsp_ready[d] = 1'b1;
      @(posedge g_clk);
      @(negedge g_clk);
      rsp_ready[d] = 1'b0;
      check("key_valid", 128'(key_valid[d]), 128'(e.kv));
      check("cmd_ready after", 128'(cmd_ready[d]), 128'd1);
   endtask

   initial begin
      g_reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d] = 1'b0;
         cmd_op[d]    = 2'b00;
         cmd_data[d]  = '0;
         rsp_ready[d] = 1'b0;
      end

      tbl[0]  = mk(2'b01, P1, 128'd0, 1'b1, 0,  1'b0);
      tbl[1]  = mk(2'b11, P1, 128'd0, 1'b1, 0,  1'b0);
      tbl[2]  = mk(2'b10, C1, 128'd0, 1'b1, 0,  1'b0);
      tbl[3]  = mk(2'b00, K1, 128'd0, 1'b0, 30, 1'b1);
      tbl[4]  = mk(2'b01, P1, C1,     1'b0, 20, 1'b1);
      tbl[5]  = mk(2'b10, C1, P1,     1'b0, 38, 1'b1);
      tbl[6]  = mk(2'b11, K1, 128'd0, 1'b1, 0,  1'b1);
      tbl[7]  = mk(2'b00, KB, 128'd0, 1'b0, 30, 1'b1);
      tbl[8]  = mk(2'b01, PB, CB,     1'b0, 20, 1'b1);
      tbl[9]  = mk(2'b10, CB, PB,     1'b0, 38, 1'b1);
      tbl[10] = mk(2'b00, K1, 128'd0, 1'b0, 30, 1'b1);
      tbl[11] = mk(2'b01, P1, C1,     1'b0, 20, 1'b1);

      repeat (3) @(negedge g_clk);
      g_reset = 1'b0;
      @(negedge g_clk);
      chk_reset(0);
      chk_reset(1);

      for (int i = 0; i < 12; i++)
         run_cmd(0, tbl[i], i % 3, 1'b0);

      // long stall in RSP plus key loads offered while busy
      run_cmd(0, mk(2'b01, P1, C1, 1'b0, 20, 1'b1), 5, 1'b1);
      run_cmd(0, mk(2'b10, C1, P1, 1'b0, 38, 1'b1), 0, 1'b1);
      run_cmd(0, mk(2'b01, P1, C1, 1'b0, 20, 1'b1), 0, 1'b0);

      // reset in the middle of an encrypt
      @(negedge g_clk);
      cmd_valid[0] = 1'b1;
      cmd_op[0]    = 2'b01;
      cmd_data[0]  = P1;
      @(negedge g_clk);
      cmd_valid[0] = 1'b0;
      repeat (11) @(negedge g_clk);
      check("mid-op busy", 128'(busy[0]), 128'd1);
      g_reset = 1'b1;
      #1;
      chk_reset(0);
      @(negedge g_clk);
      g_reset = 1'b0;
      run_cmd(0, mk(2'b01, P1, 128'd0, 1'b1, 0, 1'b0), 0, 1'b0);
      run_cmd(0, mk(2'b00, KB, 128'd0, 1'b0, 30, 1'b1), 0, 1'b0);
      run_cmd(0, mk(2'b01, PB, CB, 1'b0, 20, 1'b1), 1, 1'b0);

      // decrypt disabled instance
      run_cmd(1, mk(2'b00, K1, 128'd0, 1'b0, 30, 1'b1), 0, 1'b0);
      run_cmd(1, mk(2'b10, C1, 128'd0, 1'b1, 0,  1'b1), 2, 1'b0);
      run_cmd(1, mk(2'b01, P1, C1,     1'b0, 20, 1'b1), 0, 1'b0);

      check("scoreboard empty", 128'(sb_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
